dda_multi: RTL
==============

DDA_MULTI -- requirements
Module: dda_multi

Interface
REQ-001 SHALL provide parameter AXES, default 3: number of independent pulse/direction channels.
REQ-002 SHALL provide parameter NW, default 8: per-axis command width; MSB = direction, NW-1 LSBs = magnitude.
REQ-003 SHALL provide parameter NMAX, default 50: slots per control period, and the full-scale magnitude.
REQ-004 SHALL provide parameter DIV, default 200: clocks per half-slot; slot = 2*DIV clocks.
REQ-005 SHALL provide port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-006 SHALL provide port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL provide port wr, input, 1: command load strobe, sampled each clk.
REQ-008 SHALL provide port n, input, AXES*NW: packed commands; axis i at bits [i*NW +: NW].
REQ-009 SHALL provide port pulse, output, AXES: step pulses, one bit per axis.
REQ-010 SHALL provide port dir, output, AXES: direction, one bit per axis.
REQ-011 SHALL provide port busy, output, 1: high while a period is running.
REQ-012 SHALL provide port done, output, 1: one-clock strobe at end of the last period.
REQ-013 SHALL provide port ovr, output, 1: one-clock strobe when a pending command is overwritten.
REQ-014 SHALL provide port sat, output, AXES: per-axis flag, magnitude clamped on the most recent load.

Function
REQ-015 SHALL load all axes from one wr; magnitude above NMAX SHALL be clamped to NMAX and set sat[i]; otherwise sat[i] cleared.
REQ-016 SHALL, with wr high while idle (busy=0) at clock t, start a period at clock t+1: busy=1; dir, magnitude, accumulators loaded (acc = NMAX-1).
REQ-017 SHALL provide a one-entry shadow register: wr while busy with shadow empty stores command; no effect on current period.
REQ-018 SHALL, on wr while busy with shadow full, overwrite shadow with new command and assert ovr for one clock.
REQ-019 SHALL, in slot k of a period starting at clock P, update each acc at clock P+2*DIV*k: acc += mag; if acc >= NMAX then acc -= NMAX and slot fires.
REQ-020 SHALL drive pulse[i] high for clocks [slot start+DIV, slot start+2*DIV-1] of firing slots only, low otherwise (direction setup = DIV clocks).
REQ-021 SHALL emit exactly mag pulses per axis per period; mag = 0 gives no pulses but a full busy period.
REQ-022 SHALL size accumulators to hold 2*NMAX-1 without wrap.
REQ-023 SHALL end a period after NMAX*2*DIV clocks; with shadow full, next period SHALL start on the following clock with no gap, busy held high, shadow emptied, done not asserted.
REQ-024 SHALL, at period end with shadow empty, drop busy and assert done for one clock on the following clock; dir holds last value.
REQ-025 SHALL treat wr on the same clock as a period end as a shadow write: seamless start with that command.
REQ-026 SHALL keep dir stable for the whole period; dir changes only at a period start.

Reset
REQ-027 SHALL, with rst high, clear pulse, dir, busy, done, ovr, sat, counters and shadow valid; acc = NMAX-1.
REQ-028 SHALL give rst priority over wr; rst mid-period aborts immediately, with pulse low on the next clock and no done.

Verification (NMAX=10, DIV=2 unless stated)
REQ-029 SHALL check: idle, wr with axis0 = 0x83 -> busy from t+1 for 40 clocks; dir[0]=1; exactly 3 pulses of 2 clocks each; done at t+41.
REQ-030 SHALL check: axis magnitudes 0, 10, 15 -> 0 pulses, 10 pulses (every slot), 10 pulses with sat[2]=1.
REQ-031 SHALL check: second wr mid-period with mag 5 -> next period starts without idle clock; 5 pulses; single done after second period.
REQ-032 SHALL check: two wr during one period -> ovr strobe on the second; the second command executes, not the first.
REQ-033 SHALL check: rst at slot 4 mid-pulse -> pulse=0 and busy=0 on the next clock; no done; a new wr restarts cleanly.
REQ-034 SHALL check: defaults (NMAX=50, DIV=200), mag 49 -> 49 pulses in 20000 clocks; pulse rises no earlier than 200 clocks after a dir change.

Source files
------------

// File: rtl/dda_multi.sv
// dda_multi: multi-axis DDA step/direction pulse generator.
// A control period is NMAX slots of 2*DIV clocks. At the first clock of every
// slot each axis adds its magnitude to an accumulator; an overflow past NMAX
// marks the slot as firing, and the step pulse occupies the second half of the
// slot so that dir has DIV clocks of setup. This yields exactly mag evenly
// spread pulses per period. A one-entry shadow register queues the next
// command so back-to-back periods run without a gap.
//
// state  | meaning
// S_IDLE | no period running; wr starts a period on the next clock
// S_RUN  | period in progress; phase and slot down-counters advancing
module dda_multi #(
    parameter int AXES = 3,
    parameter int NW   = 8,
    parameter int NMAX = 50,
    parameter int DIV  = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic [AXES*NW-1:0]   n,
    output logic [AXES-1:0]      pulse,
    output logic [AXES-1:0]      dir,
    output logic                 busy,
    output logic                 done,
    output logic                 ovr,
    output logic [AXES-1:0]      sat
);
    localparam int MW = NW - 1;
    // accumulator must hold acc + mag up to 2*NMAX-1
    localparam int AW = $clog2(2 * NMAX);
    localparam int PW = $clog2(2 * DIV);
    localparam int SW = (NMAX > 1) ? $clog2(NMAX) : 1;

    localparam logic [PW-1:0] PH_TOP   = PW'(2 * DIV - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(DIV);
    localparam logic [SW-1:0] SLOT_TOP = SW'(NMAX - 1);
    localparam logic [AW-1:0] ACC_INIT = AW'(NMAX - 1);
    localparam logic [AW-1:0] FULL     = AW'(NMAX);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [AW-1:0]   acc_q [AXES];
    logic [AW-1:0]   acc_d [AXES];
    logic [AW-1:0]   mag_q [AXES];
    logic [AW-1:0]   mag_d [AXES];
    logic [AW-1:0]   acc_sum [AXES];
    logic [AXES-1:0] dir_q, dir_d;
    logic [AXES-1:0] fire_q, fire_d;
    logic [AXES-1:0] pulse_q, pulse_d;
    logic [AXES-1:0] sat_q, sat_d;
    logic            sh_vld_q, sh_vld_d;
    logic [AW-1:0]   sh_mag_q [AXES];
    logic [AW-1:0]   sh_mag_d [AXES];
    logic [AXES-1:0] sh_dir_q, sh_dir_d;
    logic            done_q, done_d;
    logic            ovr_q, ovr_d;

    logic [AW-1:0]   cmd_mag [AXES];
    logic [AXES-1:0] cmd_dir;
    logic [AXES-1:0] cmd_sat;
    logic            period_end;
    logic            slot_tick;
    logic            load_cmd;
    logic            load_sh;

    // Split the incoming command word into per-axis direction and clamped magnitude.
    always_comb begin
        cmd_dir = '0;
        cmd_sat = '0;
        for (int i = 0; i < AXES; i++) begin
            cmd_dir[i] = n[i*NW + NW - 1];
            if (32'(n[i*NW +: MW]) > NMAX) begin
                cmd_mag[i] = FULL;
                cmd_sat[i] = 1'b1;
            end else begin
                cmd_mag[i] = AW'(n[i*NW +: MW]);
            end
        end
    end

    // Per-axis accumulator candidate for the current slot.
    always_comb begin
        for (int i = 0; i < AXES; i++) begin
            acc_sum[i] = acc_q[i] + mag_q[i];
        end
    end

    // Next-state: period sequencing, slot accumulation, shadow handling and strobes.
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        slot_d   = slot_q;
        acc_d    = acc_q;
        mag_d    = mag_q;
        dir_d    = dir_q;
        fire_d   = fire_q;
        sh_vld_d = sh_vld_q;
        sh_mag_d = sh_mag_q;
        sh_dir_d = sh_dir_q;
        sat_d    = sat_q;
        done_d   = 1'b0;
        ovr_d    = 1'b0;
        pulse_d  = '0;
        load_cmd = 1'b0;
        load_sh  = 1'b0;

        period_end = (state_q == S_RUN) && (ph_q == '0) && (slot_q == '0);
        slot_tick  = (state_q == S_RUN) && (ph_q == PH_TOP);

        if (wr) begin
            sat_d = cmd_sat;
        end

        case (state_q)
            S_IDLE: begin
                if (wr) begin
                    load_cmd = 1'b1;
                end
            end
            S_RUN: begin
                if (slot_tick) begin
                    for (int i = 0; i < AXES; i++) begin
                        if (acc_sum[i] >= FULL) begin
                            acc_d[i]  = acc_sum[i] - FULL;
                            fire_d[i] = 1'b1;
                        end else begin
                            acc_d[i]  = acc_sum[i];
                            fire_d[i] = 1'b0;
                        end
                    end
                end

                if (ph_q == '0) begin
                    ph_d   = PH_TOP;
                    slot_d = slot_q - SW'(1);
                end else begin
                    ph_d = ph_q - PW'(1);
                end

                if (period_end) begin
                    // a wr landing on the final clock replaces whatever is queued
                    if (wr) begin
                        load_cmd = 1'b1;
                        ovr_d    = sh_vld_q;
                        sh_vld_d = 1'b0;
                    end else if (sh_vld_q) begin
                        load_sh  = 1'b1;
                        sh_vld_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        fire_d  = '0;
                    end
                end else if (wr) begin
                    ovr_d    = sh_vld_q;
                    sh_vld_d = 1'b1;
                    sh_mag_d = cmd_mag;
                    sh_dir_d = cmd_dir;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_cmd || load_sh) begin
            state_d = S_RUN;
            ph_d    = PH_TOP;
            slot_d  = SLOT_TOP;
            fire_d  = '0;
            dir_d   = load_cmd ? cmd_dir : sh_dir_q;
            for (int i = 0; i < AXES; i++) begin
                acc_d[i] = ACC_INIT;
                mag_d[i] = load_cmd ? cmd_mag[i] : sh_mag_q[i];
            end
        end

        // pulse is registered from next-state so the output never glitches
        if (state_d == S_RUN) begin
            pulse_d = fire_d & {AXES{ph_d < PH_HALF}};
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ph_q     <= '0;
            slot_q   <= '0;
            dir_q    <= '0;
            fire_q   <= '0;
            pulse_q  <= '0;
            sat_q    <= '0;
            sh_vld_q <= 1'b0;
            sh_dir_q <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            for (int i = 0; i < AXES; i++) begin
                acc_q[i]    <= ACC_INIT;
                mag_q[i]    <= '0;
                sh_mag_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            slot_q   <= slot_d;
            dir_q    <= dir_d;
            fire_q   <= fire_d;
            pulse_q  <= pulse_d;
            sat_q    <= sat_d;
            sh_vld_q <= sh_vld_d;
            sh_dir_q <= sh_dir_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            for (int i = 0; i < AXES; i++) begin
                acc_q[i]    <= acc_d[i];
                mag_q[i]    <= mag_d[i];
                sh_mag_q[i] <= sh_mag_d[i];
            end
        end
    end

    assign pulse = pulse_q;
    assign dir   = dir_q;
    assign busy  = (state_q == S_RUN);
    assign done  = done_q;
    assign ovr   = ovr_q;
    assign sat   = sat_q;

endmodule
